// File: rtl/xge_cfg_pkg.sv
// Shared types and MAC register map for the Wishbone configuration sequencer.
package xge_cfg_pkg;

  // MAC management register addresses
  localparam logic [7:0] CONFIG0     = 8'h00;
  localparam logic [7:0] INT_PENDING = 8'h08;
  localparam logic [7:0] INT_STATUS  = 8'h0C;
  localparam logic [7:0] INT_MASK    = 8'h10;

  localparam int unsigned ADR_W = 8;
  localparam int unsigned DAT_W = 32;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_BUS  = 2'd2,
    S_GAP  = 2'd3
  } cfg_state_e;

  typedef enum logic [1:0] {
    OWN_INIT = 2'd0,
    OWN_IRQ  = 2'd1,
    OWN_HOST = 2'd2
  } cfg_owner_e;

  // One Wishbone transfer request
  typedef struct packed {
    logic             we;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
  } wb_req_t;

endpackage

// File: rtl/xge_wb_xfer.sv
// Single Wishbone transfer engine: holds cyc/stb and the request stable until
// ack (or, with XGE_CFG_TIMEOUT_EN defined, until the ack-wait limit expires).
module xge_wb_xfer
  import xge_cfg_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clkWB,
  input  logic             wb_rst_i,
  input  logic             start_i,
  input  wb_req_t          req_i,
  output logic             cyc_o,
  output logic             stb_o,
  output wb_req_t          req_o,
  input  logic             ack_i,
  input  logic [DAT_W-1:0] rdat_i,
  output logic             done_c,
  output logic             err_c,
  output logic [DAT_W-1:0] rdat_c
);

  logic    cyc_q, cyc_d;
  wb_req_t req_q, req_d;

`ifdef XGE_CFG_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Next-state for the bus handshake and ack-wait counter
  always_comb begin
    cyc_d  = cyc_q;
    req_d  = req_q;
    done_c = cyc_q & ack_i;
    err_c  = 1'b0;
    rdat_c = rdat_i;
`ifdef XGE_CFG_TIMEOUT_EN
    cnt_d  = cnt_q;
    err_c  = cyc_q & ~ack_i & (cnt_q == CNT_W'(TIMEOUT - 1));
    if (cyc_q && !ack_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
`endif
    if (start_i && !cyc_q) begin
      cyc_d = 1'b1;
      req_d = req_i;
`ifdef XGE_CFG_TIMEOUT_EN
      cnt_d = '0;
`endif
    end else if (done_c || err_c) begin
      cyc_d = 1'b0;
    end
  end

  // Bus registers; reset drops cyc/stb immediately
  always_ff @(posedge clkWB or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      cyc_q <= 1'b0;
      req_q <= '0;
`ifdef XGE_CFG_TIMEOUT_EN
      cnt_q <= '0;
`endif
    end else begin
      cyc_q <= cyc_d;
      req_q <= req_d;
`ifdef XGE_CFG_TIMEOUT_EN
      cnt_q <= cnt_d;
`endif
    end
  end

  assign cyc_o = cyc_q;
  assign stb_o = cyc_q;
  assign req_o = req_q;

endmodule

// File: rtl/xge_wb_cfg_seq.sv
// Wishbone configuration sequencer / arbiter for the 10GE MAC management port.
// Writes an init table after reset, then arbitrates interrupt reads (priority)
// against a single-outstanding host command port.
// Optional feature macro: XGE_CFG_TIMEOUT_EN (ack-wait timeout and error reporting).
module xge_wb_cfg_seq
  import xge_cfg_pkg::*;
#(
  parameter int unsigned NUM_CFG = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                   clkWB,
  input  logic                   wb_rst_i,
  input  logic [NUM_CFG*8-1:0]   cfg_adr,
  input  logic [NUM_CFG*32-1:0]  cfg_dat,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [7:0]             host_adr,
  input  logic [31:0]            host_wdat,
  output logic                   host_gnt,
  output logic                   host_done,
  output logic [31:0]            host_rdat,
  output logic                   host_err,
  output logic [7:0]             wb_adr_i,
  output logic [31:0]            wb_dat_i,
  output logic                   wb_cyc_i,
  output logic                   wb_stb_i,
  output logic                   wb_we_i,
  input  logic                   wb_ack_o,
  input  logic [31:0]            wb_dat_o,
  input  logic                   wb_int_o,
  output logic                   init_done,
  output logic                   irq_valid,
  output logic [31:0]            irq_vec,
  output logic                   timeout_err
);

  localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  cfg_state_e       state_q, state_d;
  cfg_owner_e       own_q, own_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             host_we_q, host_we_d;
  logic             init_done_q, init_done_d;
  logic             host_gnt_q, host_gnt_d;
  logic             host_done_q, host_done_d;
  logic [31:0]      host_rdat_q, host_rdat_d;
  logic             host_err_q, host_err_d;
  logic             irq_valid_q, irq_valid_d;
  logic [31:0]      irq_vec_q, irq_vec_d;
  logic             timeout_err_q, timeout_err_d;

  logic             start_c;
  wb_req_t          req_c;
  wb_req_t          bus_req;
  logic             xfer_done_c;
  logic             xfer_err_c;
  logic [31:0]      xfer_rdat_c;
  wb_req_t          init_req_c;

  // Current init-table entry
  always_comb begin
    init_req_c.we  = 1'b1;
    init_req_c.adr = cfg_adr[8*32'(idx_q) +: 8];
    init_req_c.dat = cfg_dat[32*32'(idx_q) +: 32];
  end

  xge_wb_xfer #(
    .TIMEOUT (TIMEOUT)
  ) u_xfer (
    .clkWB    (clkWB),
    .wb_rst_i (wb_rst_i),
    .start_i  (start_c),
    .req_i    (req_c),
    .cyc_o    (wb_cyc_i),
    .stb_o    (wb_stb_i),
    .req_o    (bus_req),
    .ack_i    (wb_ack_o),
    .rdat_i   (wb_dat_o),
    .done_c   (xfer_done_c),
    .err_c    (xfer_err_c),
    .rdat_c   (xfer_rdat_c)
  );

  // Sequencing, arbitration and result routing
  always_comb begin
    state_d       = state_q;
    own_d         = own_q;
    idx_d         = idx_q;
    host_we_d     = host_we_q;
    init_done_d   = init_done_q;
    host_gnt_d    = 1'b0;
    host_done_d   = 1'b0;
    host_rdat_d   = host_rdat_q;
    host_err_d    = host_err_q;
    irq_valid_d   = 1'b0;
    irq_vec_d     = irq_vec_q;
    timeout_err_d = timeout_err_q | xfer_err_c;
    start_c       = 1'b0;
    req_c         = init_req_c;

    case (state_q)
      S_INIT: begin
        start_c = 1'b1;
        own_d   = OWN_INIT;
        state_d = S_BUS;
      end
      S_IDLE: begin
        if (wb_int_o) begin
          start_c   = 1'b1;
          req_c.we  = 1'b0;
          req_c.adr = INT_PENDING;
          req_c.dat = '0;
          own_d     = OWN_IRQ;
          state_d   = S_BUS;
        end else if (host_req) begin
          start_c    = 1'b1;
          req_c.we   = host_we;
          req_c.adr  = host_adr;
          req_c.dat  = host_wdat;
          host_we_d  = host_we;
          host_gnt_d = 1'b1;
          own_d      = OWN_HOST;
          state_d    = S_BUS;
        end
      end
      S_BUS: begin
        if (xfer_done_c || xfer_err_c) begin
          state_d = S_GAP;
          case (own_q)
            OWN_IRQ: begin
              if (xfer_done_c) begin
                irq_vec_d   = xfer_rdat_c;
                irq_valid_d = 1'b1;
              end
            end
            OWN_HOST: begin
              host_done_d = 1'b1;
              host_err_d  = xfer_err_c;
              host_rdat_d = (xfer_done_c && !host_we_q) ? xfer_rdat_c : 32'h0;
            end
            default: ;
          endcase
        end
      end
      S_GAP: begin
        if (own_q == OWN_INIT) begin
          if (idx_q < IDX_W'(NUM_CFG - 1)) begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_INIT;
          end else begin
            init_done_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clkWB or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q       <= S_INIT;
      own_q         <= OWN_INIT;
      idx_q         <= '0;
      host_we_q     <= 1'b0;
      init_done_q   <= 1'b0;
      host_gnt_q    <= 1'b0;
      host_done_q   <= 1'b0;
      host_rdat_q   <= '0;
      host_err_q    <= 1'b0;
      irq_valid_q   <= 1'b0;
      irq_vec_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      own_q         <= own_d;
      idx_q         <= idx_d;
      host_we_q     <= host_we_d;
      init_done_q   <= init_done_d;
      host_gnt_q    <= host_gnt_d;
      host_done_q   <= host_done_d;
      host_rdat_q   <= host_rdat_d;
      host_err_q    <= host_err_d;
      irq_valid_q   <= irq_valid_d;
      irq_vec_q     <= irq_vec_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign wb_adr_i    = bus_req.adr;
  assign wb_dat_i    = bus_req.dat;
  assign wb_we_i     = bus_req.we;
  assign init_done   = init_done_q;
  assign host_gnt    = host_gnt_q;
  assign host_done   = host_done_q;
  assign host_rdat   = host_rdat_q;
  assign host_err    = host_err_q;
  assign irq_valid   = irq_valid_q;
  assign irq_vec     = irq_vec_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: doc/xge_wb_cfg_seq.md
# xge_wb_cfg_seq

Wishbone configuration sequencer and bus arbiter for the 10GE MAC management port. After reset it writes a parameterised table of register values into the MAC, then shares the single Wishbone master path between interrupt servicing (reading the pending register on `wb_int_o`) and a one-outstanding host command port. It sits in the `clkWB` domain between the software/host model and the MAC `wb_*` pins.

## Interface

Parameters:
- `NUM_CFG`, default 4: number of init-table writes; must be at least 1.
- `TIMEOUT`, default 255: ack-wait limit in cycles. Used only with the macro in Configuration.

Ports:
- `clkWB`, in, 1: Wishbone clock.
- `wb_rst_i`, in, 1: asynchronous, active-high reset.
- `cfg_adr`, in, `NUM_CFG*8`: init addresses; entry k is `[8k+7:8k]`.
- `cfg_dat`, in, `NUM_CFG*32`: init data; entry k is `[32k+31:32k]`.
- `host_req`, in, 1: host command request; held until `host_gnt`.
- `host_we`, in, 1: 1 = write, 0 = read.
- `host_adr`, in, 8: host address.
- `host_wdat`, in, 32: host write data.
- `host_gnt`, out, 1: one-cycle pulse; command accepted.
- `host_done`, out, 1: one-cycle pulse; command finished.
- `host_rdat`, out, 32: read data, valid with `host_done`.
- `host_err`, out, 1: valid with `host_done`; 1 = timed out.
- `wb_adr_i`, out, 8: to MAC.
- `wb_dat_i`, out, 32: to MAC.
- `wb_cyc_i`, out, 1: to MAC.
- `wb_stb_i`, out, 1: to MAC.
- `wb_we_i`, out, 1: to MAC.
- `wb_ack_o`, in, 1: from MAC.
- `wb_dat_o`, in, 32: from MAC.
- `wb_int_o`, in, 1: MAC interrupt, level.
- `init_done`, out, 1: init table complete; stays high until reset.
- `irq_valid`, out, 1: one-cycle pulse; `irq_vec` updated.
- `irq_vec`, out, 32: last value read from `INT_PENDING`.
- `timeout_err`, out, 1: sticky; set on any timeout.

## Operation

- Reset value of every output is 0. On reset assertion, any in-flight cycle is abandoned and `cyc`/`stb` drop asynchronously.
- State machine states: `S_INIT`, `S_IDLE`, `S_BUS`, `S_GAP`.
- Transitions:
  - Reset → `S_INIT`, with index 0.
  - `S_INIT` issues a write of entry idx, then goes to `S_BUS` → `S_GAP`.
  - In `S_GAP`, if idx < `NUM_CFG`-1 the block increments idx and returns to `S_INIT`; otherwise it sets `init_done` and goes to `S_IDLE`.
- During `S_INIT`, `host_req` and `wb_int_o` are ignored (not lost; they are still sampled once in `S_IDLE`).
- `S_IDLE` arbitration is fixed priority, interrupt > host:
  - If `wb_int_o` = 1: start a read of `INT_PENDING` (0x08), which is clear-on-read.
  - Otherwise, if `host_req` = 1: pulse `host_gnt`, latch `host_we`/`host_adr`/`host_wdat`, and start that cycle.
- `S_BUS` holds `cyc`=`stb`=1 with stable adr/dat/we until `wb_ack_o` is sampled high.
- On ack:
  - Interrupt read: `irq_vec` ← `wb_dat_o` and `irq_valid` pulses.
  - Host command: `host_rdat` ← `wb_dat_o` (reads only; 0 for writes) and `host_done` pulses.
- Every cycle passes through `S_GAP`, so `cyc` is low for at least one cycle between transfers.
- If `wb_int_o` is still high in `S_IDLE` after `S_GAP`, a new interrupt read is issued. Host starvation under a stuck interrupt is accepted.
- An ack received outside `S_BUS` is ignored.

## Timing

- Decision in `S_IDLE`/`S_INIT` at edge N → `cyc`/`stb` high from edge N+1.
- With ack sampled at edge M, `cyc`/`stb` are low after edge M and `host_done`/`irq_valid` are high for cycle M+1.
- Zero-wait-state slave (ack in the first `stb` cycle): a transfer occupies 3 cycles (issue, bus, gap), so throughput is one transfer per 3 cycles.
- `host_gnt` pulses in the same cycle that `cyc` rises.
- Init with `NUM_CFG`=4 and a zero-wait slave: `init_done` rises 12 cycles after reset release.

## Configuration

- `XGE_CFG_TIMEOUT_EN` defined:
  - An 8+ bit counter runs in `S_BUS`.
  - After `TIMEOUT` cycles without ack, the block drops `cyc`/`stb` and sets `timeout_err`.
  - Host command: `host_done` pulses with `host_err`=1 and `host_rdat`=0.
  - Interrupt read: `irq_valid` is not pulsed.
  - Init write: the sequence proceeds to the next entry.
- Macro undefined:
  - `S_BUS` waits for ack indefinitely.
  - `timeout_err` and `host_err` are tied to 0.

## Structure

- Package `xge_cfg_pkg` holds:
  - MAC register address constants: `CONFIG0`=0x00, `INT_PENDING`=0x08, `INT_STATUS`=0x0C, `INT_MASK`=0x10.
  - The state enum `cfg_state_e`.
  - The owner enum `{OWN_INIT, OWN_IRQ, OWN_HOST}`.
- Sub-module `xge_wb_xfer` is the single-transfer engine:
  - Takes a start pulse with adr/dat/we.
  - Drives `cyc`/`stb`, owns the timeout counter.
  - Returns done/err/rdata.
- The top-level block holds the arbitration, the init index and the result routing.

## Test plan

- Reset, `NUM_CFG`=2, table {0x10←0x0000_00FF, 0x00←0x0000_0001}, zero-wait slave → two writes in table order, `init_done`=1 at cycle 6.
- Host read of 0x0C with slave returning 0xDEAD_BEEF after 3 wait states → `host_gnt` pulses one cycle, `host_done` pulses with `host_rdat`=0xDEAD_BEEF, `host_err`=0.
- `wb_int_o` and `host_req` rise in the same cycle in `S_IDLE` → read of 0x08 goes first and `irq_vec` = slave value (0x0000_0004). The host cycle starts only after `S_GAP`, and `cyc` is low for at least one cycle between the two.
- `host_req` held high during init → no `host_gnt` before `init_done`; the command is executed afterward.
- With `XGE_CFG_TIMEOUT_EN`, `TIMEOUT`=16, slave never acks a host write → `cyc` drops after 16 cycles, `host_err`=1, `timeout_err` stays 1. A following transfer completes normally.
- `wb_rst_i` asserted mid-`S_BUS` → `cyc`/`stb`/all outputs 0 immediately; after release, init restarts from entry 0.
